systolic_mul_4x4: RTL and testbench

- Output-stationary 4x4 systolic matrix multiplier computing C = A x B for 32-bit unsigned operands.
- Rows of A enter from the left and columns of B enter from the top, pre-skewed by the upstream feeder.
- A fixed-length run starts at reset release; done_o rises once every processing element (PE) has accumulated its last product.
- Results stay frozen after done_o until the next reset.

---
 rtl/systolic_mul_pkg.sv | 42 ++++
 rtl/systolic_pe.sv | 53 +++++
 rtl/systolic_mul_4x4.sv | 113 +++++++++++
 tb/tb_systolic_mul_4x4.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/systolic_mul_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : systolic_mul_pkg                                       |
// | Description : Shared constants, types and the per-PE accumulate step |
// |               for the 4x4 output-stationary systolic multiplier.     |
// |               SYSTOLIC_MUL_SAT_EN selects the saturating accumulate  |
// |               on the full 64-bit product.                            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package systolic_mul_pkg;

  localparam int DATA_W = 32;
  localparam int N      = 4;
  localparam int CNT_W  = 4;

  // Edge on which the last product lands in PE(N-1,N-1).
  localparam logic [CNT_W-1:0] DONE_CYCLE = CNT_W'(3*N-2);

  typedef logic [DATA_W-1:0] data_t;

  // One multiply-accumulate step. Wrapping mode keeps only the low half of
  // the product and lets the sum wrap; saturating mode keeps every bit and
  // clamps the sum at all-ones.
  function automatic data_t mac_step(input data_t acc, input data_t a, input data_t b);
`ifdef SYSTOLIC_MUL_SAT_EN
    logic [2*DATA_W-1:0] prod;
    logic [2*DATA_W:0]   sum;
    prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    sum  = {1'b0, prod} + {{(DATA_W+1){1'b0}}, acc};
    if (|sum[2*DATA_W:DATA_W]) begin
      return '1;
    end
    return sum[DATA_W-1:0];
`else
    data_t prod;
    prod = a * b;
    return acc + prod;
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_pe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : systolic_pe                                            |
// | Description : Output-stationary processing element: accumulates      |
// |               a_i*b_i while enabled and forwards a_i right / b_i     |
// |               down through one register each. Honours              |
// |               SYSTOLIC_MUL_SAT_EN through the package accumulate.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module systolic_pe
  import systolic_mul_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  en_i,
  input  data_t a_i,
  input  data_t b_i,
  output data_t a_o,
  output data_t b_o,
  output data_t acc_o
);

  data_t acc_q, acc_d;
  data_t a_q;
  data_t b_q;

  // Next accumulator value: add the product only while the run is active.
  always_comb begin
    acc_d = acc_q;
    if (en_i) begin
      acc_d = mac_step(acc_q, a_i, b_i);
    end
  end

  // Accumulator and neighbour pass registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      acc_q <= acc_d;
      a_q   <= a_i;
      b_q   <= b_i;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/systolic_mul_4x4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : systolic_mul_4x4                                       |
// | Description : 4x4 output-stationary systolic multiplier, C = A x B.  |
// |               Pre-skewed A rows enter from the left, B columns from  |
// |               the top. A fixed run starts at reset release and       |
// |               done_o stays high until the next reset.                |
// |               Optional macro SYSTOLIC_MUL_SAT_EN: saturating         |
// |               accumulation on the full-width product.                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module systolic_mul_4x4 #(
  parameter int DATA_W = 32,
  parameter int N      = 4
) (
  input  logic [DATA_W-1:0]       left_i_0,
  input  logic [DATA_W-1:0]       left_i_4,
  input  logic [DATA_W-1:0]       left_i_8,
  input  logic [DATA_W-1:0]       left_i_12,
  input  logic [DATA_W-1:0]       up_i_0,
  input  logic [DATA_W-1:0]       up_i_1,
  input  logic [DATA_W-1:0]       up_i_2,
  input  logic [DATA_W-1:0]       up_i_3,
  input  logic                    clk_i,
  input  logic                    rst_ni,
  output logic                    done_o,
  output logic [N*N*DATA_W-1:0]   c_o
);

  import systolic_mul_pkg::*;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             acc_en;

  data_t left_w [N];
  data_t up_w   [N];
  data_t a_in   [N][N];
  data_t b_in   [N][N];
  data_t a_out  [N][N];
  data_t b_out  [N][N];
  data_t acc    [N][N];

  assign left_w[0] = left_i_0;
  assign left_w[1] = left_i_4;
  assign left_w[2] = left_i_8;
  assign left_w[3] = left_i_12;
  assign up_w[0]   = up_i_0;
  assign up_w[1]   = up_i_1;
  assign up_w[2]   = up_i_2;
  assign up_w[3]   = up_i_3;

  // Products arrive on edges 1..DONE_CYCLE; afterwards every PE holds.
  assign acc_en = (cnt_q < DONE_CYCLE);

  // Saturating edge counter; done is a registered copy of "counter at end".
  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (cnt_q != DONE_CYCLE) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (cnt_d == DONE_CYCLE) begin
      done_d = 1'b1;
    end
  end

  // Run-control state with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;

  generate
    for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
        if (j == 0) begin : g_a_edge
          assign a_in[i][j] = left_w[i];
        end else begin : g_a_pass
          assign a_in[i][j] = a_out[i][j-1];
        end

        if (i == 0) begin : g_b_edge
          assign b_in[i][j] = up_w[j];
        end else begin : g_b_pass
          assign b_in[i][j] = b_out[i-1][j];
        end

        systolic_pe u_pe (
          .clk_i  (clk_i),
          .rst_ni (rst_ni),
          .en_i   (acc_en),
          .a_i    (a_in[i][j]),
          .b_i    (b_in[i][j]),
          .a_o    (a_out[i][j]),
          .b_o    (b_out[i][j]),
          .acc_o  (acc[i][j])
        );

        assign c_o[(i*N+j)*DATA_W +: DATA_W] = acc[i][j];
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_systolic_mul_4x4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_systolic_mul_4x4                                    |
// | Description : Directed self-checking bench for systolic_mul_4x4.     |
// |               Expected saturation result follows                     |
// |               SYSTOLIC_MUL_SAT_EN.                                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_systolic_mul_4x4;

  logic [31:0]  left_0, left_4, left_8, left_12;
  logic [31:0]  up_0, up_1, up_2, up_3;
  logic         clk;
  logic         rst_n;
  logic         done;
  logic [511:0] c;

  logic [31:0] ma [4][4];
  logic [31:0] mb [4][4];

  int n_checks = 0;
  int n_errors = 0;

  systolic_mul_4x4 dut (
    .left_i_0  (left_0),
    .left_i_4  (left_4),
    .left_i_8  (left_8),
    .left_i_12 (left_12),
    .up_i_0    (up_0),
    .up_i_1    (up_1),
    .up_i_2    (up_2),
    .up_i_3    (up_3),
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .done_o    (done),
    .c_o       (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cel(input int i, input int j);
    return c[(4*i+j)*32 +: 32];
  endfunction

  task automatic zero_inputs();
    left_0 = '0; left_4 = '0; left_8 = '0; left_12 = '0;
    up_0 = '0; up_1 = '0; up_2 = '0; up_3 = '0;
  endtask

  // Drive row i with A(i,k) and column j with B(k,j) for edge e = k+idx+1.
  task automatic set_edge(input int e);
    logic [31:0] l [4];
    logic [31:0] u [4];
    for (int r = 0; r < 4; r++) begin
      int k;
      k = e - 1 - r;
      l[r] = (k >= 0 && k < 4) ? ma[r][k] : 32'd0;
      u[r] = (k >= 0 && k < 4) ? mb[k][r] : 32'd0;
    end
    left_0 = l[0]; left_4 = l[1]; left_8 = l[2]; left_12 = l[3];
    up_0 = u[0]; up_1 = u[1]; up_2 = u[2]; up_3 = u[3];
  endtask

  // Hold reset for two edges; the edge after return is edge 1 of a run.
  task automatic do_reset();
    rst_n = 1'b0;
    zero_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_edges(input int last, input bit tcheck);
    for (int e = 1; e <= last; e++) begin
      set_edge(e);
      @(posedge clk);
      #1;
      if (tcheck) begin
        check($sformatf("done_e%0d", e), {31'd0, done}, (e >= 10) ? 32'd1 : 32'd0);
        if (e == 4) check("c00_e4", cel(0, 0), 32'd10);
      end
    end
    zero_inputs();
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        check($sformatf("%s_c%0d%0d", tag, i, j), cel(i, j), 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  task automatic load_first();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        ma[i][k] = 32'(4*i + k + 1);
        mb[i][k] = 32'(k + 1);
      end
  endtask

  task automatic check_first(input string tag);
    check({tag, "_c00"}, cel(0, 0), 32'd10);
    check({tag, "_c03"}, cel(0, 3), 32'd40);
    check({tag, "_c12"}, cel(1, 2), 32'd78);
    check({tag, "_c21"}, cel(2, 1), 32'd84);
    check({tag, "_c33"}, cel(3, 3), 32'd232);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    zero_inputs();
    do_reset();
    check_all_zero("rst0");

    // Scenario 1: skewed load with timing checks
    load_first();
    run_edges(10, 1'b1);
    check_first("s1");

    // Hold inputs after done: results and done must not move
    left_12 = 32'd16;
    up_3    = 32'd4;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk);
      #1;
      check("hold_c33", cel(3, 3), 32'd232);
      check("hold_done", {31'd0, done}, 32'd1);
    end
    zero_inputs();

    // Identity A times B(k,j)=4k+j+1
    do_reset();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        ma[i][k] = (i == k) ? 32'd1 : 32'd0;
        mb[i][k] = 32'(4*i + k + 1);
      end
    run_edges(10, 1'b0);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        check($sformatf("id_c%0d%0d", i, j), cel(i, j), 32'(4*i + j + 1));
    check("id_done", {31'd0, done}, 32'd1);

    // Abort a run with reset on edge 5, then rerun
    do_reset();
    load_first();
    run_edges(4, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("abort");
    @(posedge clk);
    #1;
    check_all_zero("abort2");
    rst_n = 1'b1;
    run_edges(10, 1'b0);
    check_first("rerun");

    // Overflow behaviour: every product is 2^32
    do_reset();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        ma[i][k] = 32'h0001_0000;
        mb[i][k] = 32'h0001_0000;
      end
    run_edges(10, 1'b0);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
`ifdef SYSTOLIC_MUL_SAT_EN
        check($sformatf("sat_c%0d%0d", i, j), cel(i, j), 32'hFFFF_FFFF);
`else
        check($sformatf("wrap_c%0d%0d", i, j), cel(i, j), 32'd0);
`endif
    check("ovf_done", {31'd0, done}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
